// File: rtl/ram_port_arbiter.sv
// Arbitrates the data-RAM port between the CPU load/store path and a FIFO-buffered debug loader stream.
// Optional feature macro: ARB_ADDR_CHECK_EN (restricts loader writes to the DBG_BASE/DBG_SIZE window).
module ram_port_arbiter #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] DBG_BASE   = 32'h1000_0000,
    parameter logic [31:0] DBG_SIZE   = 32'h0000_4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    output logic              hold_o,
    input  logic              dbg_en_i,
    input  logic              dbg_wr_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic              dbg_full_o,
    output logic              dbg_ovf_o,
    output logic              dbg_err_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [0:0] {S_CPU = 1'b0, S_DBG = 1'b1} state_t;

    state_t            state_r;
    logic              hold_r;
    logic              rvalid_r;
    logic              ovf_r;
    logic              dbg_en_q_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];

    logic [PTR_W-1:0]  count_s;
    logic              empty_s;
    logic              full_s;
    logic              cpu_phase_s;
    logic              gnt_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_full_s;
    logic              in_win_s;
    logic              en_rise_s;

    assign count_s     = wr_ptr_r - rd_ptr_r;
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign full_s      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                         (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
    // hold_r is still set in the first cycle after reset, which keeps the CPU out until the first clock
    assign cpu_phase_s = (state_r == S_CPU) && !hold_r;
    assign gnt_s       = cpu_phase_s && cpu_req_i;
    assign en_rise_s   = dbg_en_i && !dbg_en_q_r;
    assign push_s      = dbg_wr_i && in_win_s && (!full_s || pop_s);
    assign drop_full_s = dbg_wr_i && in_win_s && full_s && !pop_s;

`ifdef ARB_ADDR_CHECK_EN
    logic [ADDR_W:0] win_lo_s;
    logic [ADDR_W:0] win_hi_s;
    logic            err_r;

    // One extra bit so BASE+SIZE cannot wrap around the address space
    assign win_lo_s  = {1'b0, ADDR_W'(DBG_BASE)};
    assign win_hi_s  = win_lo_s + {1'b0, ADDR_W'(DBG_SIZE)};
    assign in_win_s  = ({1'b0, dbg_addr_i} >= win_lo_s) && ({1'b0, dbg_addr_i} < win_hi_s);
    assign dbg_err_o = err_r;

    // Sticky out-of-window flag, cleared on each new debug session
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (dbg_wr_i && !in_win_s) begin
            err_r <= 1'b1;
        end else if (en_rise_s) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^{DBG_BASE, DBG_SIZE};
    assign in_win_s     = 1'b1;
    assign dbg_err_o    = 1'b0;
`endif

    // Pop decision: debug mode drains every cycle, CPU mode only uses idle slots
    always_comb begin
        pop_s = 1'b0;
        if (state_r == S_DBG) begin
            pop_s = !empty_s;
        end else if (cpu_phase_s) begin
            pop_s = !cpu_req_i && !empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // RAM port mux; idle cycles drive zeros
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = {ADDR_W{1'b0}};
        ram_wdata_o = {DATA_W{1'b0}};
        if (gnt_s) begin
            ram_ce_o    = 1'b1;
            ram_we_o    = cpu_we_i;
            ram_addr_o  = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
        end else if (pop_s) begin
            ram_ce_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = fifo_addr_r[rd_ptr_r[IDX_W-1:0]];
            ram_wdata_o = fifo_data_r[rd_ptr_r[IDX_W-1:0]];
        end else begin
            ram_ce_o    = 1'b0;
        end
    end

    // Port ownership FSM; hold_r mirrors the next state so the stall is registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_CPU;
            hold_r  <= 1'b1;
        end else begin
            case (state_r)
                S_CPU: begin
                    if (dbg_en_i || (full_s && cpu_req_i)) begin
                        state_r <= S_DBG;
                        hold_r  <= 1'b1;
                    end else begin
                        state_r <= S_CPU;
                        hold_r  <= 1'b0;
                    end
                end
                S_DBG: begin
                    if (!dbg_en_i && (count_s <= PTR_W'(1))) begin
                        state_r <= S_CPU;
                        hold_r  <= 1'b0;
                    end else begin
                        state_r <= S_DBG;
                        hold_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_CPU;
                    hold_r  <= 1'b1;
                end
            endcase
        end
    end

    // Loader word FIFO storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r[IDX_W-1:0]] <= dbg_addr_i;
                fifo_data_r[wr_ptr_r[IDX_W-1:0]] <= dbg_data_i;
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Read-valid pipeline, overflow flag and debug-enable edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_r   <= 1'b0;
            ovf_r      <= 1'b0;
            dbg_en_q_r <= 1'b0;
        end else begin
            rvalid_r   <= gnt_s && !cpu_we_i;
            dbg_en_q_r <= dbg_en_i;
            if (drop_full_s) begin
                ovf_r <= 1'b1;
            end else if (en_rise_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign cpu_gnt_o    = gnt_s;
    assign cpu_rvalid_o = rvalid_r;
    assign cpu_rdata_o  = rvalid_r ? ram_rdata_i : {DATA_W{1'b0}};
    assign hold_o       = hold_r;
    assign dbg_full_o   = full_s;
    assign dbg_ovf_o    = ovf_r;

endmodule
